// File: rtl/lane_pkg.sv
// Shared constants and types for the lane distributor and lane serializer.
package lane_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;

    typedef logic [IDX_W-1:0] lane_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/next_lane_finder.sv
// Combinational priority encoder: lowest set mask bit strictly above idx_i,
// or the lowest set bit overall when from_start_i is high.
module next_lane_finder
    import lane_pkg::*;
(
    input  logic [LANES-1:0] mask_i,
    input  lane_idx_t        idx_i,
    input  logic             from_start_i,
    output lane_idx_t        next_idx_o,
    output logic             none_o
);

    // Scan downward so the lowest qualifying lane is the last one written.
    always_comb begin
        next_idx_o = '0;
        none_o     = 1'b1;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (i > int'(idx_i)))) begin
                next_idx_o = lane_idx_t'(i);
                none_o     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Snapshots eight lane values and streams the enabled ones, in ascending
// lane order, onto a single valid/ready bus tagged with the lane index.
module lane_serializer
    import lane_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LANES-1:0]  lane_en,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    input  logic [DATA_W-1:0] din4,
    input  logic [DATA_W-1:0] din5,
    input  logic [DATA_W-1:0] din6,
    input  logic [DATA_W-1:0] din7,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output lane_idx_t         dout_idx,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              done
);

    ser_state_t        state_q, state_d;
    logic [LANES-1:0]  mask_q,  mask_d;
    logic [DATA_W-1:0] bank_q [LANES];
    logic [DATA_W-1:0] bank_d [LANES];
    lane_idx_t         idx_q,   idx_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [DATA_W-1:0] din_a [LANES];
    logic [LANES-1:0]  fnd_mask;
    logic              fnd_from_start;
    lane_idx_t         fnd_next;
    logic              fnd_none;

    always_comb begin
        din_a[0] = din0;
        din_a[1] = din1;
        din_a[2] = din2;
        din_a[3] = din3;
        din_a[4] = din4;
        din_a[5] = din5;
        din_a[6] = din6;
        din_a[7] = din7;
    end

    // In IDLE the finder looks at the incoming mask for the first lane;
    // in SEND it walks the captured mask upward from the current lane.
    assign fnd_mask       = (state_q == IDLE) ? lane_en : mask_q;
    assign fnd_from_start = (state_q == IDLE);

    next_lane_finder u_finder (
        .mask_i       (fnd_mask),
        .idx_i        (idx_q),
        .from_start_i (fnd_from_start),
        .next_idx_o   (fnd_next),
        .none_o       (fnd_none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            bank_q  <= '{default: '0};
            idx_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bank_d  = bank_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    bank_d = din_a;
                    mask_d = lane_en;
                    if (!fnd_none) begin
                        state_d = SEND;
                        idx_d   = fnd_next;
                        dout_d  = din_a[fnd_next];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (dout_ready) begin
                    if (fnd_none) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = fnd_next;
                        dout_d = bank_q[fnd_next];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_idx   = idx_q;
    assign dout_valid = valid_q;
    assign done       = done_q;

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Gathers eight 32-bit lane values, snapshotted in one cycle, and sends them one beat per handshake onto a single 32-bit bus, tagged with the 3-bit lane index. It is the reverse of the registered 1-to-8 lane distributor in the FPU datapath: that block fans a bus out to eight lanes, and this block collects eight lane results back onto one bus for write-back. An optional lane-enable mask skips unused lanes.

## Interface
- DATA_W, default 32: width of each lane and of the output bus.
- LANES, default 8: number of lanes. Fixed at 8 for this revision; the index is 3 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  single-cycle request to snapshot the lanes. Accepted only in IDLE.
- lane_en  in  LANES  per-lane enable, captured together with load.
- din0..din7  in  DATA_W each  lane inputs, captured on an accepted load.
- busy  out  1  high while the block is in SEND.
- dout  out  DATA_W  value of the current lane.
- dout_idx  out  3  lane number of the current beat.
- dout_valid  out  1  beat valid.
- dout_ready  in  1  downstream accepts the beat.
- done  out  1  one-cycle pulse when a transfer completes.

## Operation
- Reset values: busy=0, dout=0, dout_idx=0, dout_valid=0, done=0. The state is IDLE and the snapshot bank and the captured mask are all zero.
- States: IDLE and SEND.
- IDLE with load=1:
  - Capture din0..din7 into the bank and capture lane_en into the mask.
  - If the mask is non-zero, set idx to the lowest set bit and go to SEND.
  - If the mask is zero, stay in IDLE and pulse done on the next cycle; no beats are sent.
- SEND:
  - dout_valid=1, dout=bank[idx], dout_idx=idx.
  - dout, dout_idx and dout_valid are held stable until dout_valid && dout_ready.
  - On a handshake, idx moves to the next higher set bit of the mask.
  - If no higher bit is set, go to IDLE and pulse done.
- load while in SEND is ignored. Lane inputs are not re-sampled and the transfer is not restarted.
- Changes on din*/lane_en after capture have no effect on the transfer in flight.
- Lanes are always sent in ascending index order. idx never wraps.
- Asynchronous reset mid-transfer aborts immediately: all outputs return to their reset values, no done pulse is issued, and the remaining beats are discarded.

## Timing
- All outputs come from registers. There is no combinational path from din*, load, lane_en or dout_ready to any output.
- Accepted load at edge N: busy=1 and dout_valid=1 with the first lane are visible after edge N.
- One beat per cycle while dout_ready stays high. k enabled lanes take k cycles of dout_valid.
- The final handshake at edge M gives done=1, busy=0 and dout_valid=0 after edge M, for exactly one cycle.
- Zero mask with load at edge N: done=1 after edge N; busy stays 0.
- A load in the same cycle that done is high is accepted, which allows back-to-back transfers with one idle cycle between beats.
- dout_ready low stalls the transfer indefinitely with the outputs held.

## Structure
- The shared package lane_pkg holds:
  - LANES and DATA_W constants.
  - lane_idx_t, a 3-bit lane index type.
  - ser_state_t enum {IDLE, SEND}.
  - The distributor uses the same constants.
- Sub-module next_lane_finder: a combinational priority encoder.
  - Inputs: mask and current idx.
  - Outputs: the next set index above idx, plus a none flag.
  - Also used for the first lane, with a "from −1" mode.

## Test plan
- Full mask: load with lane_en=8'hFF, dinK=32'h1000_000K, ready held high → 8 consecutive beats with idx 0..7 and dout 32'h1000_0000..32'h1000_0007, then done pulses one cycle after the idx-7 beat.
- Sparse mask: lane_en=8'b1010_0100 → beats idx 2, 5, 7 only, with matching data; done after the third beat; busy high for exactly 3 cycles when ready is high.
- Backpressure: during the idx-3 beat, drop ready for 4 cycles → dout, dout_idx and dout_valid are held unchanged for 4 cycles, and the transfer completes normally after ready returns.
- Ignored load and zero mask:
  - Pulse load with new din values during SEND → the output data matches the original snapshot.
  - Then load with lane_en=0 → done=1 the next cycle, with no dout_valid.
- Reset mid-transfer: assert rst_n low during the idx-4 beat → all outputs go to 0 asynchronously with no done pulse. After release, a new load with 8'h01 produces a single beat with idx 0.
- Back-to-back: assert load in the done cycle → the second transfer starts on the next cycle, with data from the second capture.
